// File: rtl/alu_control_pkg.sv
// alu_control_pkg
//   Shared definitions for the ALU control path: the 4-bit ALU operation
//   encoding driven on ALUCtrl, the 2-bit ALUOp instruction classes from the
//   main control unit, and the immediate-class opcodes understood by the
//   decoder. The ALU itself imports this package so both sides agree on codes.
package alu_control_pkg;

    // ALU operation codes. 1011-1110 are reserved and never driven.
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_NOR   = 4'b0101,
        ALU_SLT   = 4'b0110,
        ALU_SLL   = 4'b0111,
        ALU_SRL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_PASSB = 4'b1010,
        ALU_NOP   = 4'b1111
    } alu_ctrl_e;

    // Instruction classes presented on ALUOp.
    localparam logic [1:0] ALUOP_MEM    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] ALUOP_IMM    = 2'b11;

    // Opcodes decoded when ALUOp selects the immediate/shift class.
    localparam logic [3:0] OPC_ADD   = 4'b0000;
    localparam logic [3:0] OPC_SUB   = 4'b0001;
    localparam logic [3:0] OPC_SHIFT = 4'b0010;
    localparam logic [3:0] OPC_AND   = 4'b0011;
    localparam logic [3:0] OPC_OR    = 4'b0100;
    localparam logic [3:0] OPC_XOR   = 4'b0101;
    localparam logic [3:0] OPC_SLT   = 4'b0110;
    localparam logic [3:0] OPC_PASSB = 4'b0111;

endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode
//   Purely combinational decode of the ALU operation from the instruction
//   class, function field and opcode.
//   Ports:
//     ALUOp        in  2  instruction class
//     Funct        in  2  R-type function / shift-type selector
//     opcode       in  4  instruction opcode
//     ctrl_next    out 4  decoded ALU operation
//     illegal_next out 1  combination has no defined operation
module alu_ctrl_decode
    import alu_control_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [1:0] Funct,
    input  logic [3:0] opcode,
    output logic [3:0] ctrl_next,
    output logic       illegal_next
);

    always_comb begin
        ctrl_next    = ALU_NOP;
        illegal_next = 1'b0;
        case (ALUOp)
            ALUOP_MEM:    ctrl_next = ALU_ADD;
            ALUOP_BRANCH: ctrl_next = ALU_SUB;
            ALUOP_RTYPE: begin
                case (Funct)
                    2'b00:   ctrl_next = ALU_ADD;
                    2'b01:   ctrl_next = ALU_SUB;
                    2'b10:   ctrl_next = ALU_AND;
                    default: ctrl_next = ALU_OR;
                endcase
            end
            default: begin
                case (opcode)
                    OPC_ADD:   ctrl_next = ALU_ADD;
                    OPC_SUB:   ctrl_next = ALU_SUB;
                    OPC_AND:   ctrl_next = ALU_AND;
                    OPC_OR:    ctrl_next = ALU_OR;
                    OPC_XOR:   ctrl_next = ALU_XOR;
                    OPC_SLT:   ctrl_next = ALU_SLT;
                    OPC_PASSB: ctrl_next = ALU_PASSB;
                    OPC_SHIFT: begin
                        // Shift instructions reuse Funct as the shift type;
                        // Funct=11 has no fourth shift and is rejected.
                        case (Funct)
                            2'b00:   ctrl_next = ALU_SLL;
                            2'b01:   ctrl_next = ALU_SRL;
                            2'b10:   ctrl_next = ALU_SRA;
                            default: illegal_next = 1'b1;
                        endcase
                    end
                    default: illegal_next = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/alu_control.sv
// alu_control
//   Registered ALU control unit: decodes ALUOp/Funct/opcode with one cycle
//   of latency. Outputs hold their last accepted value while valid_in is low.
//   Ports:
//     clk       in  1  rising-edge clock
//     rst       in  1  synchronous active-high reset
//     ALUOp     in  2  instruction class
//     Funct     in  2  R-type function / shift-type selector
//     opcode    in  4  instruction opcode
//     valid_in  in  1  inputs valid this cycle
//     ALUCtrl   out 4  registered ALU operation
//     valid_out out 1  ALUCtrl reflects a valid_in accepted on the last edge
//     illegal   out 1  registered illegal-combination flag
module alu_control
    import alu_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] ALUOp,
    input  logic [1:0] Funct,
    input  logic [3:0] opcode,
    input  logic       valid_in,
    output logic [3:0] ALUCtrl,
    output logic       valid_out,
    output logic       illegal
);

    logic [3:0] ctrl_next;
    logic       illegal_next;
    logic [3:0] ctrl_reg;
    logic       illegal_reg;
    logic       valid_reg;

    alu_ctrl_decode u_decode (
        .ALUOp        (ALUOp),
        .Funct        (Funct),
        .opcode       (opcode),
        .ctrl_next    (ctrl_next),
        .illegal_next (illegal_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_reg    <= ALU_NOP;
            illegal_reg <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= valid_in;
            if (valid_in) begin
                ctrl_reg    <= ctrl_next;
                illegal_reg <= illegal_next;
            end
        end
    end

    assign ALUCtrl   = ctrl_reg;
    assign illegal   = illegal_reg;
    assign valid_out = valid_reg;

endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control
//   Directed and randomized stimulus for alu_control, checked against a
//   table-driven reference model of the decode rules.
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ALUOp;
    logic [1:0] Funct;
    logic [3:0] opcode;
    logic       valid_in;
    logic [3:0] ALUCtrl;
    logic       valid_out;
    logic       illegal;

    int tests  = 0;
    int failed = 0;

    // Expected registered outputs.
    logic [3:0] exp_ctrl;
    logic       exp_ill;
    logic       exp_val;

    // Reference tables: -1 = illegal, -2 = shift (consult shift_tab).
    int rtype_tab [4]  = '{0, 1, 2, 3};
    int shift_tab [4]  = '{7, 8, 9, -1};
    int imm_tab   [16] = '{0, 1, -2, 2, 3, 4, 6, 10,
                           -1, -1, -1, -1, -1, -1, -1, -1};

    alu_control dut (
        .clk       (clk),
        .rst       (rst),
        .ALUOp     (ALUOp),
        .Funct     (Funct),
        .opcode    (opcode),
        .valid_in  (valid_in),
        .ALUCtrl   (ALUCtrl),
        .valid_out (valid_out),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_decode(input logic [1:0] op,
                                              input logic [1:0] f,
                                              input logic [3:0] opc);
        int code;
        case (op)
            2'd0:    code = 0;
            2'd1:    code = 1;
            2'd2:    code = rtype_tab[f];
            default: begin
                code = imm_tab[opc];
                if (code == -2) code = shift_tab[f];
            end
        endcase
        if (code < 0) return {1'b1, 4'hF};
        return {1'b0, code[3:0]};
    endfunction

    task automatic step(input logic r, input logic v, input logic [1:0] op,
                        input logic [1:0] f, input logic [3:0] opc,
                        input string tag);
        rst = r; valid_in = v; ALUOp = op; Funct = f; opcode = opc;
        @(posedge clk);
        #1;
        if (r) begin
            exp_ctrl = 4'hF; exp_ill = 1'b0; exp_val = 1'b0;
        end else begin
            exp_val = v;
            if (v) {exp_ill, exp_ctrl} = ref_decode(op, f, opc);
        end
        tests++;
        assert (ALUCtrl === exp_ctrl) else begin
            failed++;
            $error("FAIL %s ALUCtrl got %b want %b", tag, ALUCtrl, exp_ctrl);
        end
        tests++;
        assert (illegal === exp_ill) else begin
            failed++;
            $error("FAIL %s illegal got %b want %b", tag, illegal, exp_ill);
        end
        tests++;
        assert (valid_out === exp_val) else begin
            failed++;
            $error("FAIL %s valid_out got %b want %b", tag, valid_out, exp_val);
        end
        $display("[TB] %-10s rst=%b v=%b op=%b f=%b opc=%b -> ctrl=%b ill=%b vo=%b",
                 tag, r, v, op, f, opc, ALUCtrl, illegal, valid_out);
    endtask

    initial begin
        exp_ctrl = 4'hF; exp_ill = 1'b0; exp_val = 1'b0;

        // Reset, asserted together with valid_in to show reset wins.
        step(1'b1, 1'b1, 2'b10, 2'b01, 4'h0, "reset0");
        step(1'b1, 1'b0, 2'b00, 2'b00, 4'h0, "reset1");

        // Memory address class.
        step(1'b0, 1'b1, 2'b00, 2'b00, 4'h0, "mem_add");

        // R-type by Funct.
        step(1'b0, 1'b1, 2'b10, 2'b01, 4'h1, "r_sub");
        step(1'b0, 1'b1, 2'b10, 2'b10, 4'h1, "r_and");
        step(1'b0, 1'b1, 2'b10, 2'b11, 4'h1, "r_or");

        // Shifts, including the illegal fourth shift type.
        step(1'b0, 1'b1, 2'b11, 2'b00, 4'h2, "sll");
        step(1'b0, 1'b1, 2'b11, 2'b01, 4'h2, "srl");
        step(1'b0, 1'b1, 2'b11, 2'b10, 4'h2, "sra");
        step(1'b0, 1'b1, 2'b11, 2'b11, 4'h2, "shift_ill");

        // Undefined opcode then PASSB.
        step(1'b0, 1'b1, 2'b11, 2'b00, 4'hA, "opc_ill");
        step(1'b0, 1'b1, 2'b11, 2'b00, 4'h7, "passb");

        // Reset in the middle of a valid stream, then first decode.
        step(1'b0, 1'b1, 2'b11, 2'b00, 4'h5, "stream_xor");
        step(1'b1, 1'b1, 2'b11, 2'b00, 4'h6, "mid_rst");
        step(1'b0, 1'b1, 2'b01, 2'b00, 4'h0, "post_rst");

        // Hold across a three-cycle gap.
        step(1'b0, 1'b1, 2'b01, 2'b10, 4'h3, "gap_start");
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 2'($urandom), 2'($urandom), 4'($urandom), "gap");

        // Every ALUOp=11 opcode/Funct combination.
        for (int i = 0; i < 64; i++)
            step(1'b0, 1'b1, 2'b11, 2'(i >> 4), 4'(i), "imm_sweep");

        // Randomized traffic with occasional reset and gaps.
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 2'($urandom), 2'($urandom), 4'($urandom), "random");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_control.md
ALU_CONTROL -- requirements
Module: alu_control

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 ALUOp  input  2  instruction class from main control: 00 mem-address, 01 branch, 10 R-type, 11 immediate/shift.
REQ-006 Funct  input  2  R-type function field, also shift-type selector.
REQ-007 opcode  input  4  instruction opcode.
REQ-008 valid_in  input  1  ALUOp/Funct/opcode are valid this cycle.
REQ-009 ALUCtrl  output  4  registered ALU operation code.
REQ-010 valid_out  output  1  ALUCtrl corresponds to a valid_in accepted on the previous edge.
REQ-011 illegal  output  1  registered flag: the accepted combination has no defined operation.

Function
REQ-012 ALUCtrl encodings SHALL be ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, NOR=0101, SLT=0110, SLL=0111, SRL=1000, SRA=1001, PASSB=1010, NOP=1111; codes 1011-1110 are never driven.
REQ-013 ALUOp=00 SHALL decode to ADD regardless of Funct and opcode.
REQ-014 ALUOp=01 SHALL decode to SUB regardless of Funct and opcode.
REQ-015 ALUOp=10 SHALL decode by Funct only: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-016 ALUOp=11 SHALL decode by opcode: 0000 ADD, 0001 SUB, 0011 AND, 0100 OR, 0101 XOR, 0110 SLT, 0111 PASSB.
REQ-017 ALUOp=11 with opcode=0010 SHALL decode the shift type from Funct: 00 SLL, 01 SRL, 10 SRA; Funct=11 is illegal.
REQ-018 ALUOp=11 with any other opcode (1000-1111), or with opcode=0010 and Funct=11, SHALL produce ALUCtrl=NOP with illegal=1.
REQ-019 Every legal decode SHALL produce illegal=0.
REQ-020 Latency SHALL be exactly one cycle: inputs sampled with valid_in=1 at edge N appear on ALUCtrl/illegal with valid_out=1 after edge N.
REQ-021 When valid_in=0 at an edge, ALUCtrl and illegal SHALL hold their previous values and valid_out SHALL be 0.
REQ-022 Back-to-back valid_in cycles SHALL be accepted every cycle without stall; there is no backpressure.
REQ-023 Decode SHALL be purely a function of the current inputs; no history beyond the output register.

Reset
REQ-024 rst=1 at a rising edge SHALL set ALUCtrl=NOP, illegal=0, valid_out=0, overriding valid_in.
REQ-025 The first valid_in after rst deasserts SHALL be decoded normally with the REQ-020 latency.

Structure
REQ-026 A shared package alu_control_pkg SHALL hold the ALUCtrl encoding constants and the ALUOp class constants; the ALU imports the same package.
REQ-027 The decode SHALL be one combinational sub-module, alu_ctrl_decode, with inputs ALUOp, Funct and opcode and outputs for the next ALUCtrl and illegal; the top level adds only the output registers and valid logic.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Stimulus ALUOp=00, Funct=00, opcode=0000, valid_in=1 -> next cycle ALUCtrl=0000, illegal=0, valid_out=1.
- Stimulus ALUOp=10, Funct=01, opcode=0001 -> ALUCtrl=0001 (SUB); then Funct=10 -> 0010; then Funct=11 -> 0011.
- Stimulus ALUOp=11, Funct=00, opcode=0010 -> ALUCtrl=0111 (SLL); Funct=01 -> 1000; Funct=10 -> 1001; Funct=11 -> 1111 with illegal=1.
- Stimulus ALUOp=11, opcode=1010 -> ALUCtrl=1111, illegal=1; then opcode=0111 -> ALUCtrl=1010, illegal=0.
- Stimulus rst=1 during a valid stream -> next edge ALUCtrl=1111, valid_out=0, illegal=0; after rst=0 with ALUOp=01 -> ALUCtrl=0001 one cycle later.
- Stimulus valid_in=1 (ALUOp=01), then valid_in=0 for 3 cycles -> ALUCtrl holds 0001 and valid_out=0 during the gap.
